stream_comparator: RTL
======================

// Module: stream_comparator
// PURPOSE
//   Parametrised, registered successor to the 3-bit equality comparator. Compares two WIDTH-bit
//   operand streams, one pair per valid cycle, in a selectable mode (EQ/LT/GT/NE, signed or unsigned).
//   Tracks consecutive mode-matches and flags a streak once a programmable threshold is reached.
//   Sits between operand sources and status/control logic needing per-sample and run-length results.
// PARAMETERS
//   WIDTH   8   operand width in bits (>=1)
//   CNT_W   4   width of streak counter and threshold
// PORTS
//   clk           in   1       clock, all state on rising edge
//   rst_n         in   1       asynchronous reset, active-low
//   clr           in   1       synchronous clear of counter/FSM/outputs
//   in_valid      in   1       x,y,mode,signed_cmp valid this cycle
//   x             in   WIDTH   operand A
//   y             in   WIDTH   operand B
//   mode          in   2       00 EQ (x==y), 01 LT (x<y), 10 GT (x>y), 11 NE (x!=y)
//   signed_cmp    in   1       1: LT/GT use two's complement; ignored for EQ/NE
//   match_thresh  in   CNT_W   streak length for hit; 0 = streak detection disabled
//   out_valid     out  1       registered results valid
//   eqo           out  1       x==y for the sample
//   lto           out  1       x<y (per signed_cmp)
//   gto           out  1       x>y (per signed_cmp)
//   mode_match    out  1       selected-mode result for the sample
//   match_cnt     out  CNT_W   consecutive mode_match count, saturating
//   hit           out  1       streak reached; sticky until clr/mismatch
// BEHAVIOUR
//   - Reset (rst_n=0, async): all outputs 0, FSM=IDLE, match_cnt=0.
//   - Latency 1 cycle: sample captured on edge with in_valid=1; out_valid, eqo/lto/gto,
//     mode_match, match_cnt, hit update on that edge. in_valid=0: out_valid=0, other outputs hold.
//   - Exactly one of eqo/lto/gto is 1 whenever out_valid=1.
//   - Unsigned: compare as WIDTH-bit naturals. Signed: MSB is sign; e.g. WIDTH=8, x=8'hFF, y=8'h01
//     -> lto=1 signed, gto=1 unsigned.
//   - Counter: mode_match=1 -> match_cnt+1, saturates at 2^CNT_W-1 (no wrap);
//     mode_match=0 -> match_cnt=0. Counts only valid samples; gaps do not break a streak.
//   - FSM: IDLE (cnt=0) -> COUNT on first match; COUNT -> DONE when new cnt >= match_thresh
//     (thresh!=0), hit=1 same edge; DONE holds hit=1 while matches continue;
//     any mismatch from COUNT/DONE -> IDLE, hit=0. IDLE -> DONE directly if thresh=1.
//   - match_thresh=0: hit never asserts; counter still runs.
//   - match_thresh sampled each valid cycle; lowering it below current count sets hit on next match.
//   - mode/signed_cmp may change per sample; streak uses mode_match of each sample's own mode.
//   - clr=1: next edge match_cnt=0, hit=0, out_valid=0, FSM=IDLE; clr wins over same-cycle
//     in_valid (sample discarded).
//   - rst_n asserted mid-streak: immediate return to reset values, no glitch-hold.
// TESTING
//   1 Reset: rst_n=0 mid-run -> all outputs 0 asynchronously; release -> stays 0 until in_valid.
//   2 WIDTH=3 EQ: (000,000),(001,010),(100,100) -> eqo 1,0,1; lto 0,1,0; match_cnt 1,0,1.
//   3 Signed vs unsigned, WIDTH=8, x=FF y=01: signed_cmp=1 -> lto=1; signed_cmp=0 -> gto=1.
//   4 Streak: thresh=3, EQ, 3 equal pairs with 1 idle gap -> hit=1 on 3rd result; 4th mismatch
//     -> hit=0, match_cnt=0.
//   5 Saturation: CNT_W=4, thresh=0, 20 matches -> match_cnt stops at 15, hit stays 0.
//   6 clr with in_valid same cycle during DONE -> next cycle out_valid=0, hit=0, match_cnt=0.

Source files
------------

// File: rtl/stream_comparator.sv
// stream_comparator: registered two-operand comparator with selectable mode
// (EQ/LT/GT/NE, signed or unsigned) and a saturating streak counter that
// raises a sticky hit once a programmable run length of mode matches is seen.
module stream_comparator #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [1:0]       mode,
    input  logic             signed_cmp,
    input  logic [CNT_W-1:0] match_thresh,
    output logic             out_valid,
    output logic             eqo,
    output logic             lto,
    output logic             gto,
    output logic             mode_match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             hit
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic             out_valid_q, out_valid_d;
    logic             eqo_q, eqo_d;
    logic             lto_q, lto_d;
    logic             gto_q, gto_d;
    logic             mode_match_q, mode_match_d;
    logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
    logic             hit_q, hit_d;

    logic             eq_c;
    logic             lt_c;
    logic             gt_c;
    logic             mm_c;
    logic [CNT_W-1:0] cnt_next_c;
    logic             thresh_on_c;
    logic             thresh_reached_c;

    // Per-sample relations, selected-mode result and the count this sample would produce
    always_comb begin
        eq_c = (x == y);
        if (signed_cmp) begin
            lt_c = ($signed(x) < $signed(y));
            gt_c = ($signed(x) > $signed(y));
        end else begin
            lt_c = (x < y);
            gt_c = (x > y);
        end

        case (mode)
            2'b00:   mm_c = eq_c;
            2'b01:   mm_c = lt_c;
            2'b10:   mm_c = gt_c;
            default: mm_c = ~eq_c;
        endcase

        // Saturate instead of wrapping so a long run never looks like a fresh one
        if (!mm_c) begin
            cnt_next_c = '0;
        end else if (match_cnt_q == '1) begin
            cnt_next_c = match_cnt_q;
        end else begin
            cnt_next_c = match_cnt_q + CNT_W'(1);
        end

        thresh_on_c      = (match_thresh != '0);
        thresh_reached_c = thresh_on_c && (cnt_next_c >= match_thresh);
    end

    // Streak FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Streak FSM next state: only valid, non-cleared samples move it
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = IDLE;
        end else if (in_valid) begin
            if (!mm_c) begin
                state_d = IDLE;
            end else begin
                case (state_q)
                    IDLE, COUNT: state_d = thresh_reached_c ? DONE : COUNT;
                    DONE:        state_d = thresh_on_c ? DONE : COUNT;
                    default:     state_d = IDLE;
                endcase
            end
        end
    end

    // Registered result values: load on accepted sample, zero on clear, hold otherwise
    always_comb begin
        out_valid_d  = 1'b0;
        eqo_d        = eqo_q;
        lto_d        = lto_q;
        gto_d        = gto_q;
        mode_match_d = mode_match_q;
        match_cnt_d  = match_cnt_q;
        hit_d        = (state_d == DONE);
        if (clr) begin
            eqo_d        = 1'b0;
            lto_d        = 1'b0;
            gto_d        = 1'b0;
            mode_match_d = 1'b0;
            match_cnt_d  = '0;
        end else if (in_valid) begin
            out_valid_d  = 1'b1;
            eqo_d        = eq_c;
            lto_d        = lt_c;
            gto_d        = gt_c;
            mode_match_d = mm_c;
            match_cnt_d  = cnt_next_c;
        end
    end

    // Output register bank
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            eqo_q        <= 1'b0;
            lto_q        <= 1'b0;
            gto_q        <= 1'b0;
            mode_match_q <= 1'b0;
            match_cnt_q  <= '0;
            hit_q        <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            eqo_q        <= eqo_d;
            lto_q        <= lto_d;
            gto_q        <= gto_d;
            mode_match_q <= mode_match_d;
            match_cnt_q  <= match_cnt_d;
            hit_q        <= hit_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign eqo        = eqo_q;
    assign lto        = lto_q;
    assign gto        = gto_q;
    assign mode_match = mode_match_q;
    assign match_cnt  = match_cnt_q;
    assign hit        = hit_q;

endmodule
